aclk_time_entry: RTL and testbench

//  Button-driven entry stage upstream of the alarm clock core. Turns debounced

---
 rtl/aclk_time_entry.sv | 270 +++++++++++++++++++++++++++
 tb/tb_aclk_time_entry.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aclk_time_entry.sv
// aclk_time_entry
//   Button-driven entry stage in front of the alarm clock core. Debounced
//   single-cycle button pulses edit four BCD digits (HH:MM). A commit issues
//   a held LD_time or LD_alarm strobe to the core. Inactivity while editing
//   aborts the edit and restores the last committed digits.
//
// Parameters
//   LD_CYCLES      cycles LD_time/LD_alarm stay high per commit (>= 1)
//   TIMEOUT_CYCLES consecutive button-free edit cycles before abort (>= 2)
//   BLINK_CYCLES   half-period of the edit_digit blink (>= 1)
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   btn_mode   in   pulse: toggle target time/alarm (idle only)
//   btn_next   in   pulse: enter edit / advance to next digit
//   btn_inc    in   pulse: increment the digit under edit
//   btn_set    in   pulse: commit the edited value
//   H_in1      out  hour tens digit (0..2)
//   H_in0      out  hour units digit (0..9, 0..3 when H_in1 = 2)
//   M_in1      out  minute tens digit (0..5)
//   M_in0      out  minute units digit (0..9)
//   LD_time    out  load-clock strobe
//   LD_alarm   out  load-alarm strobe
//   target     out  0 = time, 1 = alarm
//   busy       out  high whenever not idle
//   edit_digit out  one-hot {H1,H0,M1,M0} of the digit under edit, 0 otherwise
//
// Build option
//   ACLK_ENTRY_BLINK_EN : when defined, edit_digit blinks with a half-period of
//   BLINK_CYCLES (starting on, restarting on every button or digit change).
//   When undefined, edit_digit is a static one-hot and no blink counter exists.

module aclk_time_entry #(
  parameter int unsigned LD_CYCLES      = 10,
  parameter int unsigned TIMEOUT_CYCLES = 600,
  parameter int unsigned BLINK_CYCLES   = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_set,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       target,
  output logic       busy,
  output logic [3:0] edit_digit
);

  // Elaboration-time parameter sanity checks
  if (LD_CYCLES < 1) begin : g_chk_ld
    $error("aclk_time_entry: LD_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_to
    $error("aclk_time_entry: TIMEOUT_CYCLES must be >= 2");
  end
  if (BLINK_CYCLES < 1) begin : g_chk_blink
    $error("aclk_time_entry: BLINK_CYCLES must be >= 1");
  end

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned LW = $clog2(LD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_H1,
    S_H0,
    S_M1,
    S_M0,
    S_COMMIT
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // Last committed digits, restored on timeout
  logic [1:0]    c_h1;
  logic [3:0]    c_h0;
  logic [3:0]    c_m1;
  logic [3:0]    c_m0;

  logic [TW-1:0] to_cnt;
  logic [LW-1:0] ld_cnt;

  // Decoded buttons after priority: set > next > inc > mode
  logic          do_set;
  logic          do_next;
  logic          do_inc;
  logic          do_mode;
  logic          any_btn;
  logic          to_expire;
  logic          ld_done;

  logic [1:0]    h1_inc;
  logic [3:0]    h0_max;
  logic [3:0]    h0_inc;
  logic [3:0]    m1_inc;
  logic [3:0]    m0_inc;

  logic [3:0]    sel_nxt;
  logic          show;

`ifdef ACLK_ENTRY_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic          blink_restart;
  logic          blink_wrap;
`endif

  always_comb begin
    do_set    = btn_set;
    do_next   = btn_next & ~btn_set;
    do_inc    = btn_inc & ~btn_next & ~btn_set;
    do_mode   = btn_mode & ~btn_inc & ~btn_next & ~btn_set;
    any_btn   = btn_set | btn_next | btn_inc | btn_mode;
    to_expire = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    ld_done   = (ld_cnt == LW'(LD_CYCLES));

    h1_inc = (H_in1 >= 2'd2) ? 2'd0 : H_in1 + 2'd1;
    h0_max = (H_in1 == 2'd2) ? 4'd3 : 4'd9;
    h0_inc = (H_in0 >= h0_max) ? 4'd0 : H_in0 + 4'd1;
    m1_inc = (M_in1 >= 4'd5) ? 4'd0 : M_in1 + 4'd1;
    m0_inc = (M_in0 >= 4'd9) ? 4'd0 : M_in0 + 4'd1;

    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (do_next) state_nxt = S_H1;
      end
      S_H1, S_H0, S_M1, S_M0: begin
        if (do_set) begin
          state_nxt = S_COMMIT;
        end else if (do_next) begin
          case (state)
            S_H1:    state_nxt = S_H0;
            S_H0:    state_nxt = S_M1;
            S_M1:    state_nxt = S_M0;
            default: state_nxt = S_H1;
          endcase
        end else if (!any_btn && to_expire) begin
          state_nxt = S_IDLE;
        end
      end
      S_COMMIT: begin
        if (ld_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_H1:    sel_nxt = 4'b1000;
      S_H0:    sel_nxt = 4'b0100;
      S_M1:    sel_nxt = 4'b0010;
      S_M0:    sel_nxt = 4'b0001;
      default: sel_nxt = 4'b0000;
    endcase

`ifdef ACLK_ENTRY_BLINK_EN
    blink_restart = (state_nxt != state) || any_btn;
    blink_wrap    = (blink_cnt == BW'(BLINK_CYCLES - 1));
    if (blink_restart)   show = 1'b1;
    else if (blink_wrap) show = ~blink_on;
    else                 show = blink_on;
`else
    show = 1'b1;
`endif
  end

  // Outputs are registered from the next-state decode so busy/edit_digit
  // line up with the state register rather than lagging it by a cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      H_in1      <= '0;
      H_in0      <= '0;
      M_in1      <= '0;
      M_in0      <= '0;
      c_h1       <= '0;
      c_h0       <= '0;
      c_m1       <= '0;
      c_m0       <= '0;
      LD_time    <= 1'b0;
      LD_alarm   <= 1'b0;
      target     <= 1'b0;
      busy       <= 1'b0;
      edit_digit <= '0;
      to_cnt     <= '0;
      ld_cnt     <= '0;
`ifdef ACLK_ENTRY_BLINK_EN
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
`endif
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != S_IDLE);
      edit_digit <= sel_nxt & {4{show}};

      case (state)
        S_IDLE: begin
          to_cnt <= '0;
          if (do_mode) target <= ~target;
        end

        S_H1, S_H0, S_M1, S_M0: begin
          if (any_btn) begin
            to_cnt <= '0;
          end else if (to_expire) begin
            to_cnt <= '0;
            H_in1  <= c_h1;
            H_in0  <= c_h0;
            M_in1  <= c_m1;
            M_in0  <= c_m0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end

          if (do_inc) begin
            case (state)
              S_H1: begin
                H_in1 <= h1_inc;
                // Raising the tens to 2 clamps an out-of-range units digit
                if (h1_inc == 2'd2 && H_in0 > 4'd3) H_in0 <= 4'd3;
              end
              S_H0:    H_in0 <= h0_inc;
              S_M1:    M_in1 <= m1_inc;
              default: M_in0 <= m0_inc;
            endcase
          end

          if (do_set) begin
            c_h1   <= H_in1;
            c_h0   <= H_in0;
            c_m1   <= M_in1;
            c_m0   <= M_in0;
            ld_cnt <= '0;
          end
        end

        S_COMMIT: begin
          // Strobe starts the edge after entry and lasts LD_CYCLES cycles
          if (ld_done) begin
            LD_time  <= 1'b0;
            LD_alarm <= 1'b0;
            ld_cnt   <= '0;
          end else begin
            LD_time  <= ~target;
            LD_alarm <= target;
            ld_cnt   <= ld_cnt + 1'b1;
          end
        end

        default: ;
      endcase

`ifdef ACLK_ENTRY_BLINK_EN
      blink_on <= show;
      if (blink_restart || blink_wrap) blink_cnt <= '0;
      else                             blink_cnt <= blink_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_aclk_time_entry.sv
// Testbench for aclk_time_entry: directed button sequences, a behavioural
// model stepped with each stimulus cycle, a per-cycle compare process and
// hand-computed literal checks at key points.

module tb_aclk_time_entry;

  localparam int unsigned LD = 10;
  localparam int unsigned TO = 40;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_set = 1'b0;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic       LD_alarm;
  logic       target;
  logic       busy;
  logic [3:0] edit_digit;

  aclk_time_entry #(
    .LD_CYCLES(LD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_mode(btn_mode),
    .btn_next(btn_next),
    .btn_inc(btn_inc),
    .btn_set(btn_set),
    .H_in1(H_in1),
    .H_in0(H_in0),
    .M_in1(M_in1),
    .M_in0(M_in0),
    .LD_time(LD_time),
    .LD_alarm(LD_alarm),
    .target(target),
    .busy(busy),
    .edit_digit(edit_digit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int ld_t_cnt = 0;
  int ld_a_cnt = 0;

  // Model: phase 0 = idle, 1 = editing digit m_idx (0=H1..3=M0), 2 = loading
  int m_phase;
  int m_idx;
  int wd[4];
  int cd[4];
  int m_target;
  int m_quiet;
  int m_ld_left;
  int m_ld;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_idx = 0; m_target = 0; m_quiet = 0; m_ld_left = 0; m_ld = 0;
    for (int k = 0; k < 4; k++) begin
      wd[k] = 0;
      cd[k] = 0;
    end
  endtask

  task automatic model_inc(input int i);
    int lim;
    case (i)
      0: lim = 2;
      1: lim = (wd[0] == 2) ? 3 : 9;
      2: lim = 5;
      default: lim = 9;
    endcase
    wd[i] = (wd[i] >= lim) ? 0 : wd[i] + 1;
    if (i == 0 && wd[0] == 2 && wd[1] > 3) wd[1] = 3;
  endtask

  task automatic model_step(input bit s, input bit n, input bit i, input bit m);
    if (m_phase == 0) begin
      if (s) begin
      end else if (n) begin
        m_phase = 1; m_idx = 0; m_quiet = 0;
      end else if (i) begin
      end else if (m) begin
        m_target = 1 - m_target;
      end
    end else if (m_phase == 1) begin
      if (s) begin
        for (int k = 0; k < 4; k++) cd[k] = wd[k];
        m_phase = 2; m_ld_left = LD; m_ld = 0;
      end else if (n) begin
        m_idx = (m_idx + 1) % 4; m_quiet = 0;
      end else if (i) begin
        model_inc(m_idx); m_quiet = 0;
      end else if (m) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == TO) begin
          m_phase = 0; m_quiet = 0;
          for (int k = 0; k < 4; k++) wd[k] = cd[k];
        end
      end
    end else begin
      if (m_ld_left > 0) begin
        m_ld = 1; m_ld_left--;
      end else begin
        m_ld = 0; m_phase = 0;
      end
    end
  endtask

  // Per-cycle comparison against the model, sampled 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("H_in1", int'(H_in1), wd[0]);
      check("H_in0", int'(H_in0), wd[1]);
      check("M_in1", int'(M_in1), wd[2]);
      check("M_in0", int'(M_in0), wd[3]);
      check("target", int'(target), m_target);
      check("busy", int'(busy), (m_phase != 0) ? 1 : 0);
      check("edit_digit", int'(edit_digit), (m_phase == 1) ? (8 >> m_idx) : 0);
      check("LD_time", int'(LD_time), (m_ld != 0 && m_target == 0) ? 1 : 0);
      check("LD_alarm", int'(LD_alarm), (m_ld != 0 && m_target == 1) ? 1 : 0);
      if (LD_time)  ld_t_cnt++;
      if (LD_alarm) ld_a_cnt++;
    end
  end

  task automatic tick(input bit s, input bit n, input bit i, input bit m);
    btn_set = s; btn_next = n; btn_inc = i; btn_mode = m;
    model_step(s, n, i, m);
    @(posedge clk);
    @(negedge clk);
    btn_set = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_mode = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) tick(0, 0, 0, 0);
  endtask

  task automatic incs(input int k);
    for (int j = 0; j < k; j++) tick(0, 0, 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    #11;
    check("rst_busy", int'(busy), 0);
    check("rst_edit_digit", int'(edit_digit), 0);
    check("rst_ld", int'(LD_time) + int'(LD_alarm), 0);
    check("rst_digits", int'(H_in1) + int'(H_in0) + int'(M_in1) + int'(M_in0), 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Enter 23:59 and commit to the clock
    tick(0, 1, 0, 0);
    check("edit_h1_onehot", int'(edit_digit), 8);
    incs(2);
    tick(0, 1, 0, 0); incs(3);
    tick(0, 1, 0, 0); incs(5);
    tick(0, 1, 0, 0); incs(9);
    ld_t_cnt = 0; ld_a_cnt = 0;
    tick(1, 0, 0, 0);
    check("commit_busy", int'(busy), 1);
    idle(LD + 3);
    check("A_H_in1", int'(H_in1), 2);
    check("A_H_in0", int'(H_in0), 3);
    check("A_M_in1", int'(M_in1), 5);
    check("A_M_in0", int'(M_in0), 9);
    check("A_ld_time_cycles", ld_t_cnt, LD);
    check("A_ld_alarm_cycles", ld_a_cnt, 0);
    check("A_idle_busy", int'(busy), 0);

    // 19 then raise tens to 2: units clamp to 3; wrap tens to 0 keeps 3
    tick(0, 1, 0, 0); incs(2);
    check("B_h1_1", int'(H_in1), 1);
    tick(0, 1, 0, 0); incs(6);
    check("B_h0_9", int'(H_in0), 9);
    tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 1, 0, 0);
    check("B_back_h1", int'(edit_digit), 8);
    incs(1);
    check("B_clamp_h1", int'(H_in1), 2);
    check("B_clamp_h0", int'(H_in0), 3);
    incs(1);
    check("B_wrap_h1", int'(H_in1), 0);
    check("B_wrap_h0", int'(H_in0), 3);
    ld_t_cnt = 0; ld_a_cnt = 0;
    tick(1, 0, 0, 0);
    idle(LD + 3);
    check("B_ld_time_cycles", ld_t_cnt, LD);

    // Alarm target; mode during edit is ignored
    tick(0, 0, 0, 1);
    check("C_target", int'(target), 1);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 1);
    check("C_mode_in_edit", int'(target), 1);
    incs(1);
    ld_t_cnt = 0; ld_a_cnt = 0;
    tick(1, 0, 0, 0);
    idle(LD + 3);
    check("C_ld_alarm_cycles", ld_a_cnt, LD);
    check("C_ld_time_cycles", ld_t_cnt, 0);
    check("C_H_in1", int'(H_in1), 1);
    tick(1, 1, 0, 0);
    check("C_set_in_idle", int'(busy), 0);
    tick(0, 0, 0, 1);
    check("C_target_back", int'(target), 0);

    // Timeout restores committed digits without a load strobe
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 1, 0, 0);
    incs(8);
    check("D_m0_7", int'(M_in0), 7);
    ld_t_cnt = 0; ld_a_cnt = 0;
    idle(TO - 1);
    check("D_still_busy", int'(busy), 1);
    check("D_m0_held", int'(M_in0), 7);
    idle(1);
    check("D_timed_out", int'(busy), 0);
    check("D_m0_restored", int'(M_in0), 9);
    check("D_no_ld", ld_t_cnt + ld_a_cnt, 0);

    // set+next+inc together in M0, then async reset during the strobe
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 1, 0, 0);
    tick(1, 1, 1, 0);
    check("E_commit_busy", int'(busy), 1);
    check("E_m0_unchanged", int'(M_in0), 9);
    check("E_edit_off", int'(edit_digit), 0);
    idle(3);
    check("E_ld_active", int'(LD_time), 1);
    chk_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("E_rst_ld_time", int'(LD_time), 0);
    check("E_rst_busy", int'(busy), 0);
    check("E_rst_digits", int'(H_in1) + int'(H_in0) + int'(M_in1) + int'(M_in0), 0);
    check("E_rst_target", int'(target), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;
    idle(3);
    check("E_after_rst_idle", int'(busy), 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
